// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply index path.
//   DIM_W_DEF : default width of dimension counts and indices
//   dim_t     : dimension/index type at the default width
//   state_t   : sequencer FSM states (IDLE, RUN, DONE)
package matmul_pkg;
  localparam int DIM_W_DEF = 8;

  typedef logic [DIM_W_DEF-1:0] dim_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/index_sequencer_wrap_counter.sv
// Loadable up-counter that wraps at a run-time limit.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   i_clr     : force count to 0 (start of sweep / abort)
//   i_en      : advance by one, or wrap to 0 when at limit-1
//   i_limit   : count value; the index runs 0 .. i_limit-1
//   o_count   : current index
//   o_wrap    : index is at limit-1, so the next advance wraps
module wrap_counter #(
  parameter int DIM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIM_W-1:0] i_limit,
  output logic [DIM_W-1:0] o_count,
  output logic             o_wrap
);
  logic [DIM_W-1:0] r_count;

  assign o_wrap  = (r_count == i_limit - DIM_W'(1));
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + DIM_W'(1);
    end
  end
endmodule

// File: rtl/index_sequencer.sv
// Nested-loop (I outer, J, K inner) index generator for the matmul
// address stage. Latches CI/CJ/CK on start and emits one (SI,SJ,SK)
// triple per valid&ready step; flags first/last K of each (I,J) pair.
// Optional build macro INDEX_SEQ_ZERO_ERR_EN adds the dim_err output,
// which reports a start accepted with a zero dimension.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a sweep (only honoured in IDLE)
//   CI, CJ, CK          : dimension counts, latched on accepted start
//   abort               : cancel a running sweep, no done pulse
//   ready               : downstream accepts current triple
//   valid, SI, SJ, SK   : current triple
//   first_k, last_k     : triple is first / last K step of its (I,J)
//   busy, done          : not idle / one-cycle end-of-sweep pulse
//   dim_err             : (INDEX_SEQ_ZERO_ERR_EN only) zero-dimension start
import matmul_pkg::*;

module index_sequencer #(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] CI,
  input  logic [DIM_W-1:0] CJ,
  input  logic [DIM_W-1:0] CK,
  input  logic             abort,
  input  logic             ready,
  output logic             valid,
  output logic [DIM_W-1:0] SI,
  output logic [DIM_W-1:0] SJ,
  output logic [DIM_W-1:0] SK,
  output logic             first_k,
  output logic             last_k,
  output logic             busy,
  output logic             done
`ifdef INDEX_SEQ_ZERO_ERR_EN
  ,
  output logic             dim_err
`endif
);
  state_t           r_state;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [DIM_W-1:0] r_ci;
  logic [DIM_W-1:0] r_cj;
  logic [DIM_W-1:0] r_ck;

  logic             w_start_acc;
  logic             w_zero_dim;
  logic             w_clr;
  logic             w_accept;
  logic             w_wrap_i;
  logic             w_wrap_j;
  logic             w_wrap_k;
  logic             w_final;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_zero_dim  = (CI == '0) || (CJ == '0) || (CK == '0);
  // abort outranks the handshake, so an aborted cycle never advances
  assign w_accept    = (r_state == RUN) && !abort && ready;
  assign w_clr       = w_start_acc || ((r_state == RUN) && abort);
  assign w_final     = w_accept && w_wrap_k && w_wrap_j && w_wrap_i;

  // wrap flags chain K -> J -> I
  wrap_counter #(.DIM_W(DIM_W)) u_cnt_k (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_accept),
    .i_limit(r_ck), .o_count(SK), .o_wrap(w_wrap_k)
  );

  wrap_counter #(.DIM_W(DIM_W)) u_cnt_j (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_accept && w_wrap_k),
    .i_limit(r_cj), .o_count(SJ), .o_wrap(w_wrap_j)
  );

  wrap_counter #(.DIM_W(DIM_W)) u_cnt_i (
    .clk(clk), .rst(rst), .i_clr(w_clr),
    .i_en(w_accept && w_wrap_k && w_wrap_j),
    .i_limit(r_ci), .o_count(SI), .o_wrap(w_wrap_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ci    <= '0;
      r_cj    <= '0;
      r_ck    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_ci   <= CI;
            r_cj   <= CJ;
            r_ck   <= CK;
            r_busy <= 1'b1;
            if (w_zero_dim) begin
              // nothing to iterate: report completion without a valid cycle
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_final) begin
            r_state <= DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign valid   = r_valid;
  assign busy    = r_busy;
  assign done    = r_done;
  assign first_k = r_valid && (SK == '0);
  assign last_k  = r_valid && w_wrap_k;

`ifdef INDEX_SEQ_ZERO_ERR_EN
  logic r_dim_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dim_err <= 1'b0;
    end else if (w_start_acc) begin
      r_dim_err <= w_zero_dim;
    end
  end

  assign dim_err = r_dim_err;
`endif
endmodule

// File: tb/tb_index_sequencer.sv
module tb_index_sequencer;
  localparam int DIM_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [DIM_W-1:0] CI = '0;
  logic [DIM_W-1:0] CJ = '0;
  logic [DIM_W-1:0] CK = '0;
  logic             abort = 1'b0;
  logic             ready = 1'b0;
  logic             valid;
  logic [DIM_W-1:0] SI;
  logic [DIM_W-1:0] SJ;
  logic [DIM_W-1:0] SK;
  logic             first_k;
  logic             last_k;
  logic             busy;
  logic             done;
`ifdef INDEX_SEQ_ZERO_ERR_EN
  logic             dim_err;
`endif

  int checks = 0;
  int errors = 0;

  index_sequencer #(.DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .CI(CI), .CJ(CJ), .CK(CK),
    .abort(abort), .ready(ready), .valid(valid), .SI(SI), .SJ(SJ), .SK(SK),
    .first_k(first_k), .last_k(last_k), .busy(busy), .done(done)
`ifdef INDEX_SEQ_ZERO_ERR_EN
    , .dim_err(dim_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] triple(input int n, input int cj, input int ck);
    return {8'h00, 8'(n / (ck * cj)), 8'((n / ck) % cj), 8'(n % ck)};
  endfunction

  function automatic logic [31:0] obs_triple();
    return {8'h00, SI, SJ, SK};
  endfunction

  // Full sweep with bench-side index model. rmode 0: ready held 1;
  // rmode 1: ready pattern 1,0,0,1 repeating. mid_ci != 0 re-pulses start
  // with CI=mid_ci at cycle 10 of the sweep.
  task automatic run_sweep(input int ci, input int cj, input int ck,
                           input int rmode, input int mid_ci,
                           output int acc, output int fk, output int lk);
    int  n;
    int  last_acc_cyc;
    int  done_cyc;
    bit  stop;
    bit  fin;
    CI = DIM_W'(ci); CJ = DIM_W'(cj); CK = DIM_W'(ck);
    start = 1'b1; ready = 1'b0;
    step();
    start = 1'b0;
    n = 0; acc = 0; fk = 0; lk = 0;
    last_acc_cyc = -10; done_cyc = -1; stop = 0; fin = 0;
    for (int cyc = 0; cyc < 400 && !stop; cyc++) begin
      ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      start = (mid_ci != 0) && (cyc == 10);
      if (start) CI = DIM_W'(mid_ci);
      if (done) begin
        fin = 1; stop = 1; done_cyc = cyc;
        chk("valid_at_done", 32'(valid), 32'(0));
      end else if (!valid) begin
        chk("valid_in_sweep", 32'(valid), 32'(1));
        stop = 1;
      end else begin
        chk("triple", obs_triple(), triple(n, cj, ck));
        chk("first_k", 32'(first_k), 32'((n % ck) == 0));
        chk("last_k", 32'(last_k), 32'((n % ck) == ck - 1));
        if (first_k) fk++;
        if (last_k) lk++;
        if (ready) begin
          acc++; n++; last_acc_cyc = cyc;
        end
        step();
      end
    end
    ready = 1'b0; start = 1'b0;
    chk("done_seen", 32'(fin), 32'(1));
    chk("done_latency", 32'(done_cyc), 32'(last_acc_cyc + 1));
    step();
    chk("done_pulse_len", 32'(done), 32'(0));
    chk("busy_after_done", 32'(busy), 32'(0));
  endtask

  initial begin
    int acc;
    int fk;
    int lk;

    // reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_outputs", {valid, busy, done, first_k, last_k, 3'b000, SI, SJ, SK}, 32'h0);
`ifdef INDEX_SEQ_ZERO_ERR_EN
    chk("rst_dim_err", 32'(dim_err), 32'(0));
`endif
    // abort in IDLE is a no-op
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", {valid, busy, done}, 32'h0);

    // basic sweep 3x4x5
    run_sweep(3, 4, 5, 0, 0, acc, fk, lk);
    chk("basic_accepts", 32'(acc), 32'(60));
    chk("basic_first_k", 32'(fk), 32'(12));
    chk("basic_last_k", 32'(lk), 32'(12));
`ifdef INDEX_SEQ_ZERO_ERR_EN
    chk("basic_dim_err", 32'(dim_err), 32'(0));
`endif

    // backpressure 2x2x2
    run_sweep(2, 2, 2, 1, 0, acc, fk, lk);
    chk("bp_accepts", 32'(acc), 32'(8));

    // CK=1: every step is both first and last
    run_sweep(2, 2, 1, 0, 0, acc, fk, lk);
    chk("ck1_accepts", 32'(acc), 32'(4));
    chk("ck1_first_k", 32'(fk), 32'(4));
    chk("ck1_last_k", 32'(lk), 32'(4));

    // ignored start mid-sweep
    run_sweep(3, 4, 5, 0, 7, acc, fk, lk);
    chk("midstart_accepts", 32'(acc), 32'(60));

    // zero dimension: straight to done
    CI = 8'd0; CJ = 8'd3; CK = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_valid", 32'(valid), 32'(0));
    chk("zero_done", 32'(done), 32'(1));
    chk("zero_busy", 32'(busy), 32'(1));
`ifdef INDEX_SEQ_ZERO_ERR_EN
    chk("zero_dim_err", 32'(dim_err), 32'(1));
`endif
    step();
    chk("zero_done_end", {valid, busy, done}, 32'h0);
`ifdef INDEX_SEQ_ZERO_ERR_EN
    chk("zero_dim_err_hold", 32'(dim_err), 32'(1));
`endif

    // abort at step 17 of a 3x4x5 sweep
    CI = 8'd3; CJ = 8'd4; CK = 8'd5;
    start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    for (int s = 0; s < 17; s++) step();
    chk("abort_pre_triple", obs_triple(), triple(17, 4, 5));
    abort = 1'b1;
    step();
    abort = 1'b0; ready = 1'b0;
    chk("abort_outputs", {valid, busy, done}, 32'h0);
    step();
    chk("abort_no_done", 32'(done), 32'(0));
    run_sweep(3, 4, 5, 0, 0, acc, fk, lk);
    chk("after_abort_accepts", 32'(acc), 32'(60));
`ifdef INDEX_SEQ_ZERO_ERR_EN
    chk("restart_dim_err", 32'(dim_err), 32'(0));
`endif

    // reset at step 30
    CI = 8'd3; CJ = 8'd4; CK = 8'd5;
    start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    for (int s = 0; s < 30; s++) step();
    chk("rst_pre_triple", obs_triple(), triple(30, 4, 5));
    rst = 1'b1;
    step();
    rst = 1'b0; ready = 1'b0;
    chk("midrst_outputs", {valid, busy, done, first_k, last_k, 3'b000, SI, SJ, SK}, 32'h0);
    step();
    chk("midrst_no_done", {valid, busy, done}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
